piezo_event_capture: RTL and testbench

Receive-side counterpart to the piezo transmit path. It synchronizes the acoustic event_trigger comparator input and detects rising edges with a programmable hold-off. Each accepted edge is timestamped with the RTC time and pushed into a FIFO. The HPS drains the FIFO over an Avalon-MM slave, and the block raises an interrupt while data is pending. It sits beside rtc_0 in soc_system and feeds the triangulation software.

---
 rtl/piezo_event_capture.sv | 190 +++++++++++++++++++
 tb/tb_piezo_event_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/piezo_event_capture.sv
// Piezo receive path: synchronizes the comparator edge, timestamps accepted
// edges against rtc_time into a FIFO, and exposes the FIFO over Avalon-MM.
module piezo_event_capture #(
    parameter int TS_WIDTH       = 64,
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                event_trigger,
    input  logic [TS_WIDTH-1:0] rtc_time,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic                irq,
    output logic                capture_pulse
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   enable_q, enable_d;
    logic                   irq_en_q, irq_en_d;
    logic                   overflow_q, overflow_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [31:0]            shadow_q, shadow_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   irq_q, irq_d;

    logic [TS_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    head;
    logic [TS_WIDTH-1:0]    cap_ts;
    logic                   capture;
    logic                   empty, full;
    logic                   wr_ctrl, flush, pop, push;
    logic [31:0]            status;

    assign head          = mem[rd_ptr_q];
    // Captured edge has travelled SYNC_STAGES flops plus the edge register.
    assign cap_ts        = rtc_time - TS_WIDTH'(SYNC_STAGES + 1);
    assign empty         = (level_q == '0);
    assign full          = (level_q == LVL_W'(FIFO_DEPTH));
    assign capture_pulse = capture;
    assign irq           = irq_q;
    assign avs_readdata  = readdata_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], event_trigger};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!enable_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (edge_q) begin
                        capture = 1'b1;
                        cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
                        state_d = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) state_d = ARMED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ctrl = avs_write && (avs_address == 2'd0);
        flush   = wr_ctrl && avs_writedata[31];
        pop     = avs_read && (avs_address == 2'd2) && !empty && !flush;
        push    = capture && !flush && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end

        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        if (wr_ctrl) begin
            enable_d = avs_writedata[0];
            irq_en_d = avs_writedata[1];
            if (avs_writedata[17]) overflow_d = 1'b0;
        end
        // A fresh drop outranks a same-cycle clear so no lost entry goes unseen.
        if (capture && !flush && full && !pop) overflow_d = 1'b1;

        irq_d = irq_en_q & ~empty;
    end

    always_comb begin
        status       = '0;
        status[0]    = enable_q;
        status[1]    = irq_en_q;
        status[15:8] = 8'(level_q);
        status[16]   = empty;
        status[17]   = full;
        status[18]   = overflow_q;

        readdata_d = '0;
        shadow_d   = shadow_q;
        if (avs_read) begin
            case (avs_address)
                2'd0: readdata_d = status;
                2'd1: begin
                    if (!empty) begin
                        readdata_d = head[31:0];
                        shadow_d   = head[63:32];
                    end
                end
                2'd2: readdata_d = shadow_q;
                default: readdata_d = 32'(FIFO_DEPTH);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cap_ts;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_q     <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shadow_q   <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            shadow_q   <= shadow_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_piezo_event_capture.sv
// Directed bench for piezo_event_capture: capture timing, holdoff, FIFO full/
// overflow, pop-with-push, timestamp wrap, enable gating, flush and reset.
module tb_piezo_event_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        event_trigger = 1'b0;
    logic [63:0] rtc_time = 64'd0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        irq;
    logic        capture_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    piezo_event_capture #(
        .TS_WIDTH(64), .FIFO_DEPTH(16), .SYNC_STAGES(2), .HOLDOFF_CYCLES(1000)
    ) dut (
        .clk(clk), .reset(reset), .event_trigger(event_trigger), .rtc_time(rtc_time),
        .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_write(avs_write), .avs_writedata(avs_writedata),
        .irq(irq), .capture_pulse(capture_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rtc_time = rtc_time + 64'd1;
        cyc++;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // Raise the trigger for three cycles; the capture strobe lands on the third.
    task automatic pulse_trig(input string tag, input logic exp_cap, output logic [63:0] ts);
        ts = rtc_time;
        event_trigger = 1'b1;
        repeat (3) tick();
        check(tag, capture_pulse, exp_cap);
        event_trigger = 1'b0;
        tick();
    endtask

    logic [31:0] rd;
    logic [63:0] ts_a, ts_b, ts_c, ts_new;
    logic [63:0] ts_tab [17];
    int r0;

    initial begin
        repeat (3) tick();
        check("rst_irq", irq, 1'b0);
        check("rst_cap", capture_pulse, 1'b0);
        reset = 1'b0;
        tick();
        avs_rd(2'd0, rd); check("rst_status", rd, 32'h0001_0000);
        avs_rd(2'd3, rd); check("depth", rd, 32'd16);

        // Single capture at rtc 1500
        avs_wr(2'd0, 32'h3);
        rtc_time = 64'd1000;
        while (rtc_time != 64'd1500) tick();
        pulse_trig("cap1", 1'b1, ts_a);
        check("irq_lag", irq, 1'b0);
        tick();
        check("irq_up", irq, 1'b1);
        avs_rd(2'd0, rd); check("lvl1", rd, 32'h0000_0103);
        avs_rd(2'd1, rd); check("ts1_lo", rd, 32'd1500);
        avs_rd(2'd2, rd); check("ts1_hi", rd, 32'd0);
        avs_rd(2'd0, rd); check("lvl0", rd, 32'h0001_0003);
        tick();
        check("irq_down", irq, 1'b0);

        // Holdoff
        wait_to(cyc + 1010);
        r0 = cyc;
        pulse_trig("ho_first", 1'b1, ts_a);
        wait_to(r0 + 10);
        pulse_trig("ho_masked", 1'b0, ts_b);
        wait_to(r0 + 1001);
        pulse_trig("ho_after", 1'b1, ts_c);
        avs_rd(2'd0, rd); check("ho_lvl2", rd, 32'h0000_0203);
        avs_rd(2'd1, rd); check("ho_e0_lo", rd, ts_a[31:0]);
        avs_rd(2'd2, rd); check("ho_e0_hi", rd, ts_a[63:32]);
        avs_rd(2'd1, rd); check("ho_e1_lo", rd, ts_c[31:0]);
        avs_rd(2'd2, rd); check("ho_e1_hi", rd, ts_c[63:32]);

        // Fill past full
        for (int i = 0; i < 17; i++) begin
            wait_to(cyc + 1006);
            pulse_trig("fill_cap", 1'b1, ts_tab[i]);
        end
        avs_rd(2'd0, rd); check("full_ovf", rd, 32'h0006_1003);
        avs_wr(2'd0, 32'h0002_0003);
        avs_rd(2'd0, rd); check("ovf_clr", rd, 32'h0002_1003);

        // Pop and capture in the same cycle while full
        avs_rd(2'd1, rd); check("pp_head_lo", rd, ts_tab[0][31:0]);
        wait_to(cyc + 1010);
        ts_new = rtc_time;
        event_trigger = 1'b1;
        repeat (3) tick();
        check("pp_cap", capture_pulse, 1'b1);
        avs_address = 2'd2;
        avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        check("pp_head_hi", avs_readdata, ts_tab[0][63:32]);
        event_trigger = 1'b0;
        tick();
        avs_rd(2'd0, rd); check("pp_status", rd, 32'h0002_1003);
        for (int i = 1; i < 16; i++) begin
            avs_rd(2'd1, rd); check("drain_lo", rd, ts_tab[i][31:0]);
            avs_rd(2'd2, rd); check("drain_hi", rd, ts_tab[i][63:32]);
        end
        avs_rd(2'd1, rd); check("tail_lo", rd, ts_new[31:0]);
        avs_rd(2'd2, rd); check("tail_hi", rd, ts_new[63:32]);
        avs_rd(2'd0, rd); check("drained", rd, 32'h0001_0003);

        // Timestamp wrap: capture cycle sees rtc_time = 1
        wait_to(cyc + 1010);
        rtc_time = 64'hFFFF_FFFF_FFFF_FFFE;
        pulse_trig("wrap_cap", 1'b1, ts_a);
        avs_rd(2'd1, rd); check("wrap_lo", rd, 32'hFFFF_FFFE);
        avs_rd(2'd2, rd); check("wrap_hi", rd, 32'hFFFF_FFFF);

        // Enable gating during holdoff
        wait_to(cyc + 1010);
        pulse_trig("en_cap", 1'b1, ts_a);
        avs_wr(2'd0, 32'h2);
        repeat (4) tick();
        pulse_trig("dis_edge", 1'b0, ts_b);
        avs_rd(2'd0, rd); check("dis_status", rd, 32'h0000_0102);
        avs_wr(2'd0, 32'h3);
        repeat (2) tick();
        pulse_trig("reen_cap", 1'b1, ts_c);
        avs_rd(2'd0, rd); check("reen_lvl", rd, 32'h0000_0203);
        check("pre_rst_irq", irq, 1'b1);

        // Asynchronous reset in the middle of holdoff
        #2 reset = 1'b1;
        #1;
        check("arst_irq", irq, 1'b0);
        check("arst_rdata", avs_readdata, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        avs_rd(2'd0, rd); check("arst_status", rd, 32'h0001_0000);

        // Flush
        avs_wr(2'd0, 32'h3);
        tick();
        pulse_trig("fl_cap", 1'b1, ts_a);
        avs_rd(2'd0, rd); check("fl_pre", rd, 32'h0000_0103);
        avs_wr(2'd0, 32'h8000_0003);
        avs_rd(2'd0, rd); check("fl_post", rd, 32'h0001_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
